seg7_scan_controller: RTL and testbench

- Memory-mapped controller that owns the 4-digit 7-segment display driven on the CPU's `real_digital[11:0]` output.
- The CPU data-memory stage writes one control/data register. The block then time-multiplexes the four digits autonomously.
- Modes: hex-decoded scan mode, or raw mode where software drives anodes and segments directly.
- Sits beside data memory on the CPU's peripheral bus, decoding its own address.

---
 rtl/seg7_scan_controller_if.sv | 19 +
 rtl/seg7_scan_controller.sv | 121 ++++++++++++
 tb/tb_seg7_scan_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_controller_if.sv
// Peripheral-bus bundle between the CPU MEM stage and the 7-segment display controller.
interface seg7_scan_controller_if;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;

    modport master (
        output mem_write, mem_read, addr, wdata,
        input  rdata, rdata_valid
    );

    modport slave (
        input  mem_write, mem_read, addr, wdata,
        output rdata, rdata_valid
    );
endinterface

// File: rtl/seg7_scan_controller.sv
// Memory-mapped 4-digit 7-segment controller: one control/data register, autonomous
// digit multiplexing with anti-ghost blanking, or raw software-driven anodes/segments.
module seg7_scan_controller #(
    parameter int          SCAN_DIV  = 100000,
    parameter int          BLANK_CYC = 2,
    parameter logic [31:0] DIGI_ADDR = 32'h4000_0010
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_controller_if.slave bus,
    output logic [11:0]           real_digital
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic {
        SCAN,
        BLANK
    } state_t;

    state_t           state, state_next;
    logic [24:0]      disp_reg;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic [BLK_W-1:0] blank_cnt, blank_cnt_next;
    logic [11:0]      digital_next;
    logic [6:0]       hex_seg;
    logic [3:0]       nibble;
    logic [3:0]       enable;
    logic [3:0]       dp;
    logic             hit;
    logic             terminal;
    logic             unused_wdata_hi;

    assign hit             = (bus.addr == DIGI_ADDR);
    assign terminal        = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign nibble          = disp_reg[{idx, 2'b00} +: 4];
    assign enable          = disp_reg[19:16];
    assign dp              = disp_reg[23:20];
    assign unused_wdata_hi = ^bus.wdata[31:25];

    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // which is what makes a read beside a write return the old register contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= SCAN;
            disp_reg        <= '0;
            scan_cnt        <= '0;
            idx             <= '0;
            blank_cnt       <= '0;
            real_digital    <= 12'hFFF;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
        end else begin
            state     <= state_next;
            blank_cnt <= blank_cnt_next;
            scan_cnt  <= terminal ? '0 : scan_cnt + 1'b1;
            if (terminal)
                idx <= idx + 2'd1;
            if (bus.mem_write && hit)
                disp_reg <= bus.wdata[24:0];
            bus.rdata_valid <= bus.mem_read && hit;
            if (bus.mem_read && hit)
                bus.rdata <= {7'b0, disp_reg};
            real_digital <= digital_next;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next     = state;
        blank_cnt_next = blank_cnt;
        case (state)
            SCAN: begin
                if (terminal && BLANK_CYC != 0) begin
                    state_next     = BLANK;
                    blank_cnt_next = '0;
                end
            end
            BLANK: begin
                if (blank_cnt == BLK_W'(BLANK_CYC - 1)) begin
                    state_next     = SCAN;
                    blank_cnt_next = '0;
                end else begin
                    blank_cnt_next = blank_cnt + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}
    always_comb begin
        case (nibble)
            4'h0:    hex_seg = 7'h40;
            4'h1:    hex_seg = 7'h79;
            4'h2:    hex_seg = 7'h24;
            4'h3:    hex_seg = 7'h30;
            4'h4:    hex_seg = 7'h19;
            4'h5:    hex_seg = 7'h12;
            4'h6:    hex_seg = 7'h02;
            4'h7:    hex_seg = 7'h78;
            4'h8:    hex_seg = 7'h00;
            4'h9:    hex_seg = 7'h10;
            4'hA:    hex_seg = 7'h08;
            4'hB:    hex_seg = 7'h03;
            4'hC:    hex_seg = 7'h46;
            4'hD:    hex_seg = 7'h21;
            4'hE:    hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    end

    always_comb begin
        digital_next = 12'hFFF;
        if (disp_reg[24])
            digital_next = disp_reg[11:0];
        else if (state == SCAN && enable[idx])
            digital_next = {~(4'b0001 << idx), ~dp[idx], hex_seg};
    end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized and directed bench for seg7_scan_controller against a time-based display model.
module tb_seg7_scan_controller;
    localparam int          D    = 8;
    localparam int          B    = 2;
    localparam logic [31:0] ADDR = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] real_digital;

    seg7_scan_controller_if bus ();

    seg7_scan_controller #(
        .SCAN_DIV (D),
        .BLANK_CYC(B),
        .DIGI_ADDR(ADDR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .real_digital(real_digital)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: t = clock edges since reset release.
    int          t = 0;
    logic [24:0] m_disp = '0;
    logic [11:0] m_out = 12'hFFF;
    logic [31:0] m_rdata = '0;
    logic        m_valid = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Display contents implied by elapsed time and register value.
    function automatic logic [11:0] model_out(input int tt, input logic [24:0] d);
        int         digit;
        logic [3:0] an;
        logic [3:0] nib;
        digit = (tt / D) % 4;
        if (d[24]) return d[11:0];
        if (tt >= D && (tt % D) < B) return 12'hFFF;
        if (!d[16 + digit]) return 12'hFFF;
        an        = 4'hF;
        an[digit] = 1'b0;
        nib       = 4'((d >> (4 * digit)) & 25'hF);
        return {an, ~d[20 + digit], hex_tab[nib]};
    endfunction

    task automatic step(input logic rst, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        reset         = rst;
        bus.mem_write = w;
        bus.mem_read  = r;
        bus.addr      = a;
        bus.wdata     = wd;
        @(posedge clk);
        if (rst) begin
            m_out = 12'hFFF; m_disp = '0; m_rdata = '0; m_valid = 1'b0; t = 0;
        end else begin
            m_out   = model_out(t, m_disp);
            m_valid = r && (a == ADDR);
            if (m_valid) m_rdata = {7'b0, m_disp};
            if (w && a == ADDR) m_disp = wd[24:0];
            t++;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (real_digital !== 12'hFFF) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d real_digital=%h expected fff", i, real_digital);
            end
        end
        checks++;
        if (bus.rdata !== 32'h0 || bus.rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus rdata=%h valid=%b expected 0/0", bus.rdata, bus.rdata_valid);
        end
        for (int i = 0; i < 4 * D; i++) begin
            idle();
            checks++;
            if (real_digital !== 12'hFFF) begin
                failures++;
                $display("FAIL reset_idle t=%0d real_digital=%h expected fff", t, real_digital);
            end
        end
    endtask

    // Scans a 4*D window and checks each expected lit pattern appears D-B times.
    task automatic test_hex_scan();
        int n_e, n_d, n_b, n_7, n_off;
        n_e = 0; n_d = 0; n_b = 0; n_7 = 0; n_off = 0;
        step(1'b0, 1'b1, 1'b0, ADDR, 32'h000F_1234);
        for (int i = 0; i < D + 1 + 4 * D; i++) begin
            idle();
            checks++;
            if (real_digital !== m_out) begin
                failures++;
                $display("FAIL hex_scan t=%0d real_digital=%h expected %h", t, real_digital, m_out);
            end
            if (i > D) begin
                case (real_digital)
                    12'hE99: n_e++;
                    12'hDB0: n_d++;
                    12'hBA4: n_b++;
                    12'h7F9: n_7++;
                    12'hFFF: n_off++;
                    default: ;
                endcase
            end
        end
        checks++;
        if (n_e != D - B || n_d != D - B || n_b != D - B || n_7 != D - B || n_off != 4 * B) begin
            failures++;
            $display("FAIL hex_scan_counts e=%0d d=%0d b=%0d 7=%0d off=%0d expected %0d each, off %0d",
                     n_e, n_d, n_b, n_7, n_off, D - B, 4 * B);
        end
    endtask

    task automatic test_enable_dp();
        int n0, n2, n_off;
        n0 = 0; n2 = 0; n_off = 0;
        step(1'b0, 1'b1, 1'b0, ADDR, 32'h0015_00F0);
        for (int i = 0; i < 1 + 4 * D; i++) begin
            idle();
            checks++;
            if (real_digital !== m_out) begin
                failures++;
                $display("FAIL enable_dp t=%0d real_digital=%h expected %h", t, real_digital, m_out);
            end
            if (i > 0) begin
                if (real_digital == 12'hE40) n0++;
                else if (real_digital == 12'hBC0) n2++;
                else if (real_digital == 12'hFFF) n_off++;
            end
        end
        checks++;
        if (n0 != D - B || n2 != D - B || n_off != 4 * D - 2 * (D - B)) begin
            failures++;
            $display("FAIL enable_dp_counts d0=%0d d2=%0d off=%0d expected %0d/%0d/%0d",
                     n0, n2, n_off, D - B, D - B, 4 * D - 2 * (D - B));
        end
    endtask

    task automatic test_raw_mode();
        step(1'b0, 1'b1, 1'b0, ADDR, 32'h01FF_0A5C);
        for (int i = 0; i < 2 * D; i++) begin
            idle();
            checks++;
            if (real_digital !== 12'hA5C || m_out !== 12'hA5C) begin
                failures++;
                $display("FAIL raw_mode t=%0d real_digital=%h expected a5c", t, real_digital);
            end
        end
        step(1'b0, 1'b1, 1'b0, ADDR, 32'h000F_1234);
        for (int i = 0; i < 2 * D; i++) begin
            idle();
            checks++;
            if (real_digital !== m_out) begin
                failures++;
                $display("FAIL raw_exit t=%0d real_digital=%h expected %h", t, real_digital, m_out);
            end
        end
    endtask

    task automatic test_bus_decode();
        step(1'b0, 1'b1, 1'b0, ADDR + 32'd4, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b1, ADDR + 32'd4, 32'h0);
        checks++;
        if (bus.rdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL bus_wrong_read valid=%b expected 0", bus.rdata_valid);
        end
        step(1'b0, 1'b1, 1'b1, ADDR, 32'h0000_0001);
        checks++;
        if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h000F_1234) begin
            failures++;
            $display("FAIL bus_read_old valid=%b rdata=%h expected 1/000f1234", bus.rdata_valid, bus.rdata);
        end
        idle();
        checks++;
        if (bus.rdata_valid !== 1'b0 || bus.rdata !== 32'h000F_1234) begin
            failures++;
            $display("FAIL bus_hold valid=%b rdata=%h expected 0/000f1234", bus.rdata_valid, bus.rdata);
        end
        step(1'b0, 1'b0, 1'b1, ADDR, 32'h0);
        checks++;
        if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h0000_0001) begin
            failures++;
            $display("FAIL bus_read_new valid=%b rdata=%h expected 1/00000001", bus.rdata_valid, bus.rdata);
        end
        step(1'b0, 1'b1, 1'b0, ADDR, 32'h000F_1234);
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        for (int i = 0; i < 4 * D && ((t / D) % 4) != 2; i++) idle();
        checks++;
        if (((t / D) % 4) != 2) begin
            failures++;
            $display("FAIL mid_reach digit=%0d expected 2", (t / D) % 4);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (real_digital !== 12'hFFF) begin
            failures++;
            $display("FAIL mid_reset real_digital=%h expected fff", real_digital);
        end
        step(1'b0, 1'b0, 1'b1, ADDR, 32'h0);
        checks++;
        if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reg_cleared valid=%b rdata=%h expected 1/00000000", bus.rdata_valid, bus.rdata);
        end
        step(1'b0, 1'b1, 1'b0, ADDR, 32'h000F_1234);
        seen = 1'b0;
        for (int i = 0; i < 4 * D && !seen; i++) begin
            idle();
            if (real_digital !== 12'hFFF) begin
                seen = 1'b1;
                checks++;
                if (real_digital !== 12'hE99) begin
                    failures++;
                    $display("FAIL mid_restart first=%h expected e99", real_digital);
                end
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL mid_restart no lit digit within %0d cycles", 4 * D);
        end
    endtask

    task automatic test_random();
        logic        w, r, rst;
        logic [31:0] a;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            w   = ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1:    a = ADDR;
                2:       a = ADDR ^ (32'h1 << $urandom_range(0, 31));
                default: a = $urandom;
            endcase
            step(rst, w, r, a, $urandom);
            checks++;
            if (real_digital !== m_out || bus.rdata_valid !== m_valid || bus.rdata !== m_rdata) begin
                failures++;
                $display("FAIL random t=%0d out=%h/%h valid=%b/%b rdata=%h/%h (actual/expected)",
                         t, real_digital, m_out, bus.rdata_valid, m_valid, bus.rdata, m_rdata);
            end
        end
    endtask

    initial begin
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        test_reset();
        test_hex_scan();
        test_enable_dp();
        test_raw_mode();
        test_bus_decode();
        test_reset_mid_scan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
